val2_shift_pipe: RTL and testbench

//  Registered, parametrised operand-2 generator for the EXE stage: immediate rotate, shift by

---
 rtl/val2_shift_pipe.sv | 176 +++++++++++++++++
 tb/tb_val2_shift_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/val2_shift_pipe.sv
// val2_shift_pipe
//   Registered operand-2 generator for the EXE stage. It covers the immediate
//   rotate, shift by immediate, shift by register (Rs[7:0]), RRX and the
//   LDR/STR offset pass-through, with the ARM edge-case encodings. A single
//   output register sits behind a valid/ready handshake, so EXE can stall
//   without losing a result.
//
//   Build option:
//     VAL2_CARRY_OUT_EN  defined   -> the carry_out port and the shifter carry
//                                     logic are present; the carry is registered
//                                     together with Val_2.
//                        undefined -> there is no carry_out port. carry_in only
//                                     feeds RRX, and Val_2 is unchanged.
//
//   Ports
//     clk, rst_n          rising-edge clock, async active-low reset
//     in_valid/in_ready   request handshake (in_ready = !out_valid | out_ready)
//     I                   immediate operand select
//     mem_read_or_write   LDR/STR offset pass-through (highest priority)
//     reg_shift           shift amount comes from reg_s instead of the shamt field
//     shifter_operand     rot[11:8] imm8[7:0] | shamt[11:7] type[6:5]
//     reg_2               Rm value
//     reg_s               Rs[7:0] shift amount
//     carry_in            CPSR.C
//     out_valid/out_ready result handshake
//     Val_2               operand 2
//     carry_out           shifter carry (only with VAL2_CARRY_OUT_EN)
module val2_shift_pipe #(
  parameter int DATA_W = 32,
  parameter int OFFS_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              I,
  input  logic              mem_read_or_write,
  input  logic              reg_shift,
  input  logic [OFFS_W-1:0] shifter_operand,
  input  logic [DATA_W-1:0] reg_2,
  input  logic [7:0]        reg_s,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Val_2
`ifdef VAL2_CARRY_OUT_EN
  ,
  output logic              carry_out
`endif
);

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // DATA_W is a power of two, so "n mod DATA_W" reduces to a mask.
  localparam logic [7:0] ROT_MASK = 8'(DATA_W - 1);

  // A shift of DATA_W produces zero, so a rotate by 0 falls through cleanly.
  function automatic logic [DATA_W-1:0] ror_f(input logic [DATA_W-1:0] x,
                                              input logic [7:0]        m);
    return (x >> m) | (x << (DATA_W - int'(m)));
  endfunction

  logic [7:0]        imm_rot2;
  logic [DATA_W-1:0] imm_val;
  logic [7:0]        sh_n;
  logic [1:0]        sh_type;
  logic              imm_zero;
  logic              n_ge_w;
  logic [7:0]        rot_m;
  logic              accept;

  logic [DATA_W-1:0] val_d, val_q;
  logic              valid_d, valid_q;

  assign imm_rot2 = {3'b000, shifter_operand[11:8], 1'b0};
  assign imm_val  = ror_f(DATA_W'(shifter_operand[7:0]), imm_rot2);

  // The full 8-bit register amount is kept; range checks run before any reduction.
  assign sh_n     = reg_shift ? reg_s : {3'b000, shifter_operand[11:7]};
  assign sh_type  = shifter_operand[6:5];
  // An immediate #0 selects special encodings: LSR/ASR #32 and RRX.
  assign imm_zero = !reg_shift && (sh_n == 8'd0);
  assign n_ge_w   = int'(sh_n) >= DATA_W;
  assign rot_m    = sh_n & ROT_MASK;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    val_d = reg_2;
    if (mem_read_or_write) begin
      val_d = DATA_W'(shifter_operand);
    end else if (I) begin
      val_d = imm_val;
    end else begin
      case (sh_type)
        SH_LSL: val_d = n_ge_w ? '0 : (reg_2 << sh_n);
        SH_LSR: val_d = (imm_zero || n_ge_w) ? '0 : (reg_2 >> sh_n);
        SH_ASR: begin
          if (imm_zero || n_ge_w) val_d = {DATA_W{reg_2[DATA_W-1]}};
          else                    val_d = $signed(reg_2) >>> sh_n;
        end
        SH_ROR: val_d = imm_zero ? {carry_in, reg_2[DATA_W-1:1]} : ror_f(reg_2, rot_m);
        default: val_d = reg_2;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (accept)         valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      val_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) val_q <= val_d;
    end
  end

  assign out_valid = valid_q;
  assign Val_2     = val_q;

`ifdef VAL2_CARRY_OUT_EN
  logic              n_gt_w;
  logic [DATA_W-1:0] lsl_t;
  logic [DATA_W-1:0] rsh_t;
  logic [DATA_W-1:0] ror_t;
  logic              carry_d, carry_q;

  assign n_gt_w = int'(sh_n) > DATA_W;
  // Last bit shifted out: shift by n-1 and pick the edge bit. For n == DATA_W
  // this gives reg_2[0] (LSL) and reg_2[MSB] (LSR) with no extra case.
  assign lsl_t  = reg_2 << (sh_n - 8'd1);
  assign rsh_t  = reg_2 >> (sh_n - 8'd1);
  assign ror_t  = reg_2 >> (rot_m - 8'd1);

  always_comb begin
    carry_d = carry_in;
    if (mem_read_or_write) begin
      carry_d = carry_in;
    end else if (I) begin
      carry_d = (shifter_operand[11:8] == 4'd0) ? carry_in : imm_val[DATA_W-1];
    end else if (reg_shift && (sh_n == 8'd0)) begin
      carry_d = carry_in;
    end else begin
      case (sh_type)
        SH_LSL: carry_d = imm_zero ? carry_in : (n_gt_w ? 1'b0 : lsl_t[DATA_W-1]);
        SH_LSR: carry_d = imm_zero ? reg_2[DATA_W-1] : (n_gt_w ? 1'b0 : rsh_t[0]);
        SH_ASR: carry_d = (imm_zero || n_ge_w) ? reg_2[DATA_W-1] : rsh_t[0];
        SH_ROR: begin
          if (imm_zero)              carry_d = reg_2[0];
          else if (rot_m == 8'd0)    carry_d = reg_2[DATA_W-1];
          else                       carry_d = ror_t[0];
        end
        default: carry_d = carry_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      carry_q <= 1'b0;
    else if (accept) carry_q <= carry_d;
  end

  assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_val2_shift_pipe.sv
module tb_val2_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        I;
  logic        mem_read_or_write;
  logic        reg_shift;
  logic [11:0] shifter_operand;
  logic [31:0] reg_2;
  logic [7:0]  reg_s;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Val_2;
`ifdef VAL2_CARRY_OUT_EN
  logic        carry_out;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  val2_shift_pipe #(.DATA_W(32), .OFFS_W(12)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .I                (I),
    .mem_read_or_write(mem_read_or_write),
    .reg_shift        (reg_shift),
    .shifter_operand  (shifter_operand),
    .reg_2            (reg_2),
    .reg_s            (reg_s),
    .carry_in         (carry_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .Val_2            (Val_2)
`ifdef VAL2_CARRY_OUT_EN
    ,
    .carry_out        (carry_out)
`endif
  );

  typedef struct packed {
    logic        mem;
    logic        imm;
    logic        rsh;
    logic [11:0] so;
    logic [31:0] r2;
    logic [7:0]  rs;
    logic        cin;
    logic [31:0] ev;
    logic        ec;
  } vec_t;

  function automatic vec_t mk(input logic mem, input logic imm, input logic rsh,
                              input logic [11:0] so, input logic [31:0] r2,
                              input logic [7:0] rs, input logic cin,
                              input logic [31:0] ev, input logic ec);
    vec_t v;
    v.mem = mem; v.imm = imm; v.rsh = rsh; v.so = so; v.r2 = r2;
    v.rs = rs; v.cin = cin; v.ev = ev; v.ec = ec;
    return v;
  endfunction

  // Presents one request for a single cycle; returns #1 after the accepting edge.
  task automatic apply_op(input vec_t v);
    @(negedge clk);
    mem_read_or_write = v.mem;
    I                 = v.imm;
    reg_shift         = v.rsh;
    shifter_operand   = v.so;
    reg_2             = v.r2;
    reg_s             = v.rs;
    carry_in          = v.cin;
    in_valid          = 1'b1;
    out_ready         = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got %b want 0", out_valid); n_err++;
    end
    n_vec++;
    if (Val_2 !== 32'h0) begin
      $display("FAIL reset_val2 got %h want 00000000", Val_2); n_err++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got %b want 1", in_ready); n_err++;
    end
`ifdef VAL2_CARRY_OUT_EN
    n_vec++;
    if (carry_out !== 1'b0) begin
      $display("FAIL reset_carry got %b want 0", carry_out); n_err++;
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL post_reset_idle out_valid got %b want 0", out_valid); n_err++;
    end
  endtask

  task automatic test_imm_rotate;
    vec_t t[4];
    t[0] = mk(0, 1, 0, 12'h2FF, 32'h0, 8'd0, 1'b0, 32'hF000000F, 1'b1);
    t[1] = mk(0, 1, 0, 12'h0AB, 32'h0, 8'd0, 1'b1, 32'h000000AB, 1'b1);
    t[2] = mk(0, 1, 0, 12'hF01, 32'h0, 8'd0, 1'b1, 32'h00000004, 1'b0);
    t[3] = mk(0, 1, 0, 12'h1FF, 32'h0, 8'd0, 1'b0, 32'hC000003F, 1'b1);
    foreach (t[k]) begin
      apply_op(t[k]);
      n_vec++;
      if (out_valid !== 1'b1 || Val_2 !== t[k].ev) begin
        $display("FAIL imm_rotate[%0d] got valid=%b Val_2=%h want valid=1 Val_2=%h",
                 k, out_valid, Val_2, t[k].ev);
        n_err++;
      end
`ifdef VAL2_CARRY_OUT_EN
      n_vec++;
      if (carry_out !== t[k].ec) begin
        $display("FAIL imm_rotate_c[%0d] got %b want %b", k, carry_out, t[k].ec); n_err++;
      end
`endif
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL imm_rotate_drain out_valid got %b want 0", out_valid); n_err++;
    end
  endtask

  task automatic test_imm_shift;
    vec_t t[9];
    t[0] = mk(0, 0, 0, 12'h020, 32'h80000001, 8'd0, 1'b0, 32'h00000000, 1'b1);
    t[1] = mk(0, 0, 0, 12'h040, 32'h80000001, 8'd0, 1'b0, 32'hFFFFFFFF, 1'b1);
    t[2] = mk(0, 0, 0, 12'h060, 32'h00000003, 8'd0, 1'b1, 32'h80000001, 1'b1);
    t[3] = mk(0, 0, 0, 12'h060, 32'h00000002, 8'd0, 1'b0, 32'h00000001, 1'b0);
    t[4] = mk(0, 0, 0, 12'h200, 32'hF000000F, 8'd0, 1'b0, 32'h000000F0, 1'b1);
    t[5] = mk(0, 0, 0, 12'h000, 32'h12345678, 8'd0, 1'b1, 32'h12345678, 1'b1);
    t[6] = mk(0, 0, 0, 12'h420, 32'h123456F8, 8'd0, 1'b0, 32'h00123456, 1'b1);
    t[7] = mk(0, 0, 0, 12'h240, 32'h80000010, 8'd0, 1'b1, 32'hF8000001, 1'b0);
    t[8] = mk(0, 0, 0, 12'h460, 32'h12345678, 8'd0, 1'b1, 32'h78123456, 1'b0);
    foreach (t[k]) begin
      apply_op(t[k]);
      n_vec++;
      if (out_valid !== 1'b1 || Val_2 !== t[k].ev) begin
        $display("FAIL imm_shift[%0d] got valid=%b Val_2=%h want valid=1 Val_2=%h",
                 k, out_valid, Val_2, t[k].ev);
        n_err++;
      end
`ifdef VAL2_CARRY_OUT_EN
      n_vec++;
      if (carry_out !== t[k].ec) begin
        $display("FAIL imm_shift_c[%0d] got %b want %b", k, carry_out, t[k].ec); n_err++;
      end
`endif
    end
  endtask

  task automatic test_reg_shift;
    vec_t t[11];
    t[0]  = mk(0, 0, 1, 12'hF80, 32'hFFFFFFFF, 8'd33,  1'b1, 32'h00000000, 1'b0);
    t[1]  = mk(0, 0, 1, 12'hF80, 32'hFFFFFFFF, 8'd32,  1'b0, 32'h00000000, 1'b1);
    t[2]  = mk(0, 0, 1, 12'h000, 32'hF000000F, 8'd4,   1'b0, 32'h000000F0, 1'b1);
    t[3]  = mk(0, 0, 1, 12'h020, 32'h80000000, 8'd32,  1'b0, 32'h00000000, 1'b1);
    t[4]  = mk(0, 0, 1, 12'h020, 32'h80000000, 8'd40,  1'b1, 32'h00000000, 1'b0);
    t[5]  = mk(0, 0, 1, 12'h040, 32'h80000000, 8'd200, 1'b0, 32'hFFFFFFFF, 1'b1);
    t[6]  = mk(0, 0, 1, 12'h060, 32'h12345678, 8'd36,  1'b0, 32'h81234567, 1'b1);
    t[7]  = mk(0, 0, 1, 12'h060, 32'h80000001, 8'd64,  1'b0, 32'h80000001, 1'b1);
    t[8]  = mk(0, 0, 1, 12'h020, 32'h00001234, 8'd0,   1'b0, 32'h00001234, 1'b0);
    t[9]  = mk(0, 0, 1, 12'h040, 32'h80000010, 8'd4,   1'b1, 32'hF8000001, 1'b0);
    t[10] = mk(0, 0, 1, 12'hFA0, 32'h00000003, 8'd1,   1'b0, 32'h00000001, 1'b1);
    foreach (t[k]) begin
      apply_op(t[k]);
      n_vec++;
      if (out_valid !== 1'b1 || Val_2 !== t[k].ev) begin
        $display("FAIL reg_shift[%0d] got valid=%b Val_2=%h want valid=1 Val_2=%h",
                 k, out_valid, Val_2, t[k].ev);
        n_err++;
      end
`ifdef VAL2_CARRY_OUT_EN
      n_vec++;
      if (carry_out !== t[k].ec) begin
        $display("FAIL reg_shift_c[%0d] got %b want %b", k, carry_out, t[k].ec); n_err++;
      end
`endif
    end
  endtask

  task automatic test_mem_offset;
    vec_t t[2];
    t[0] = mk(1, 1, 1, 12'hABC, 32'hFFFFFFFF, 8'd33, 1'b1, 32'h00000ABC, 1'b1);
    t[1] = mk(1, 0, 0, 12'h060, 32'h00000003, 8'd0,  1'b0, 32'h00000060, 1'b0);
    foreach (t[k]) begin
      apply_op(t[k]);
      n_vec++;
      if (out_valid !== 1'b1 || Val_2 !== t[k].ev) begin
        $display("FAIL mem_offset[%0d] got valid=%b Val_2=%h want valid=1 Val_2=%h",
                 k, out_valid, Val_2, t[k].ev);
        n_err++;
      end
`ifdef VAL2_CARRY_OUT_EN
      n_vec++;
      if (carry_out !== t[k].ec) begin
        $display("FAIL mem_offset_c[%0d] got %b want %b", k, carry_out, t[k].ec); n_err++;
      end
`endif
    end
  endtask

  task automatic test_stall;
    apply_op(mk(1, 0, 0, 12'h5A5, 32'h0, 8'd0, 1'b1, 32'h000005A5, 1'b1));
    out_ready         = 1'b0;
    mem_read_or_write = 1'b1;
    shifter_operand   = 12'h111;
    carry_in          = 1'b0;
    in_valid          = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL stall_in_ready got %b want 0", in_ready); n_err++;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || Val_2 !== 32'h000005A5 || in_ready !== 1'b0) begin
        $display("FAIL stall_hold[%0d] got valid=%b Val_2=%h in_ready=%b want 1/000005a5/0",
                 c, out_valid, Val_2, in_ready);
        n_err++;
      end
`ifdef VAL2_CARRY_OUT_EN
      n_vec++;
      if (carry_out !== 1'b1) begin
        $display("FAIL stall_carry[%0d] got %b want 1", c, carry_out); n_err++;
      end
`endif
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || Val_2 !== 32'h000005A5) begin
      $display("FAIL stall_drain got valid=%b Val_2=%h want 0/000005a5", out_valid, Val_2);
      n_err++;
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_read_or_write = 1'b1;
      I                 = 1'b0;
      reg_shift         = 1'b0;
      shifter_operand   = 12'(12'h100 + i);
      carry_in          = i[0];
      in_valid          = 1'b1;
      out_ready         = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); n_err++;
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || Val_2 !== 32'(32'h100 + i)) begin
        $display("FAIL b2b_result[%0d] got valid=%b Val_2=%h want 1/%h",
                 i, out_valid, Val_2, 32'(32'h100 + i));
        n_err++;
      end
`ifdef VAL2_CARRY_OUT_EN
      n_vec++;
      if (carry_out !== i[0]) begin
        $display("FAIL b2b_carry[%0d] got %b want %b", i, carry_out, i[0]); n_err++;
      end
`endif
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL b2b_end out_valid got %b want 0", out_valid); n_err++;
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_read_or_write = 1'b1;
      shifter_operand   = 12'(12'h7F0 + i);
      carry_in          = 1'b1;
      in_valid          = 1'b1;
      out_ready         = 1'b1;
      @(posedge clk);
    end
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || Val_2 !== 32'h000007F2) begin
      $display("FAIL reset_mid_pre got valid=%b Val_2=%h want 1/000007f2", out_valid, Val_2);
      n_err++;
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || Val_2 !== 32'h0) begin
      $display("FAIL reset_mid_async got valid=%b Val_2=%h want 0/00000000", out_valid, Val_2);
      n_err++;
    end
`ifdef VAL2_CARRY_OUT_EN
    n_vec++;
    if (carry_out !== 1'b0) begin
      $display("FAIL reset_mid_carry got %b want 0", carry_out); n_err++;
    end
`endif
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        $display("FAIL reset_mid_stale[%0d] out_valid got %b want 0", c, out_valid); n_err++;
      end
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    in_valid          = 1'b0;
    out_ready         = 1'b1;
    I                 = 1'b0;
    mem_read_or_write = 1'b0;
    reg_shift         = 1'b0;
    shifter_operand   = 12'h000;
    reg_2             = 32'h0;
    reg_s             = 8'd0;
    carry_in          = 1'b0;
    test_reset();
    test_imm_rotate();
    test_imm_shift();
    test_reg_shift();
    test_mem_offset();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
